upc_loop_event_tracker: RTL
===========================

# upc_loop_event_tracker

Cycle-accurate event extractor that sits directly upstream of the pipelined-loop sampling monitor in the cosim dataflow monitor. It watches a design's loop FSM and handshake signals (current state, iteration start/end states, block and enable qualifiers, start/done). Each cycle with activity becomes one timestamped record, pushed into a small FIFO. The monitor drains the FIFO through a valid/ready port, so the monitor never has to sample raw FSM state itself.

## Interface
- STATE_W, 3: width of FSM state encoding
- TS_W, 32: timestamp counter width
- IDX_W, 16: iteration index width
- DEPTH, 8: record FIFO depth (power of two, ≥2)
- REC_W (derived, not overridable): 4 + 2*IDX_W + TS_W

Ports:
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cur_state  in  STATE_W  loop FSM current state
- iter_start_state  in  STATE_W  state encoding where iterations start
- iter_end_state  in  STATE_W  state encoding where iterations end
- iter_start_block  in  1  stage stall for start stage
- iter_end_block  in  1  stage stall for end stage
- iter_start_enable  in  1  pipeline enable of first iteration stage
- iter_end_enable  in  1  pipeline enable of last iteration stage
- loop_start  in  1  loop/module ap_start
- loop_done  in  1  loop done
- finish  in  1  end-of-simulation request
- out_valid  out  1  record available
- out_data  out  REC_W  {flags[3:0], start_idx, end_idx, ts}; flags = {done, iter_end, iter_start, loop_start}
- out_ready  in  1  consumer accepts record
- busy  out  1  high in RUN
- overflow  out  1  sticky: a record was dropped
- drop_count  out  16  dropped records, saturating at 16'hFFFF
- err_underflow  out  1  sticky: iter_end seen with zero in-flight iterations
- drained  out  1  high in DONE

## Operation
- Event qualifiers, evaluated each cycle:
  - S = (cur_state==iter_start_state) & iter_start_enable & ~iter_start_block.
  - E = (cur_state==iter_end_state) & iter_end_enable & ~iter_end_block.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: loop_start=1 accepts the loop. Set flag loop_start, clear start_cnt/end_cnt/inflight, go to RUN. loop_done is ignored in IDLE.
  - RUN: loop_start is ignored (ap_start held). loop_done=1 sets flag done and returns to IDLE.
  - S/E are counted only in RUN or in the IDLE→RUN acceptance cycle; elsewhere they are ignored.
  - finish=1 in any state goes to DRAIN. It takes priority over all other transitions, and no record is written in that cycle or after.
  - DRAIN goes to DONE when the FIFO is empty.
  - DONE holds until reset.
- Record contents:
  - start_idx = start_cnt before increment, valid when flag iter_start is set.
  - end_idx = end_cnt before increment.
  - ts = timestamp value in the event cycle.
  - Unflagged index fields are driven 0.
- Counters:
  - start_cnt and end_cnt are IDX_W bits and wrap modulo 2^IDX_W.
  - inflight += S − E. S and E in the same cycle leave it unchanged.
  - E with inflight==0 and no S in the same cycle sets err_underflow. The record is still written and inflight stays 0.
- At most one record per cycle, written iff any flag is set. Simultaneous loop_start+S, or S+E+done, share one record.
- FIFO behaviour:
  - A write when full is dropped unless out_ready & out_valid in the same cycle, in which case it is accepted.
  - A drop sets overflow and increments drop_count.

## Timing
- Timestamp is 0 in the first cycle after reset deasserts, increments every cycle, and wraps at 2^TS_W.
- Latency: a record for an event in cycle N is visible on out_valid/out_data in cycle N+1.
- out_data is stable while out_valid & ~out_ready. FIFO order is preserved.
- Reset values: out_valid=0, out_data=0, busy=0, overflow=0, drop_count=0, err_underflow=0, drained=0. FSM=IDLE, all counters 0, FIFO empty.
- Reset asserted mid-loop or mid-drain discards FIFO contents and all sticky flags in the next cycle.
- busy is registered: high in the cycle after IDLE→RUN, low in the cycle after loop_done.

## Test plan
- **Single iteration.** Reset, loop_start at ts=5, S at ts=6, E at ts=8, loop_done at ts=9. Required: four records:
  - {0001, 0, 0, 5}
  - {0010, 0, 0, 6}
  - {0100, 0, 0, 8}
  - {1000, 0, 0, 9}
- **Pipelined overlap.** S every cycle for 4 cycles, with E starting 2 cycles later. Required: start_idx 0..3 and end_idx 0..3 in order; the middle cycles carry flags 0110 with paired indices.
- **Backpressure.** out_ready=0 for 10 events with DEPTH=8. Required: overflow=1 and drop_count=2; the first 8 records are intact. A full FIFO plus a same-cycle pop accepts the write.
- **Underflow.** E in RUN with no prior S. Required: err_underflow=1, record {0100, 0, 0, ts}, inflight stays 0.
- **Finish during RUN with 3 queued records.** Required: no new records after finish; drained=1 one cycle after the 3rd pop.
- **Index wrap.** With IDX_W=4, run 17 iterations. Required: the 17th start_idx is 0.

Source files
------------

// File: rtl/upc_loop_event_tracker.sv
// upc_loop_event_tracker
// Watches a pipelined loop FSM plus its start/done handshake and turns each
// active cycle into one timestamped record {flags, start_idx, end_idx, ts}.
// Records are queued in a small FIFO and drained through a valid/ready port.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for loop_start; loop_done ignored
// RUN   | loop accepted; S/E counted, loop_done returns to IDLE
// DRAIN | finish seen; no more records, wait for the FIFO to empty
// DONE  | FIFO drained after finish; held until reset
module upc_loop_event_tracker #(
    parameter int STATE_W = 3,
    parameter int TS_W    = 32,
    parameter int IDX_W   = 16,
    parameter int DEPTH   = 8,
    localparam int REC_W  = 4 + 2 * IDX_W + TS_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               loop_start,
    input  logic               loop_done,
    input  logic               finish,
    output logic               out_valid,
    output logic [REC_W-1:0]   out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic               overflow,
    output logic [15:0]        drop_count,
    output logic               err_underflow,
    output logic               drained
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [TS_W-1:0]  ts;
    logic [IDX_W-1:0] start_cnt, end_cnt, inflight;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;

    logic             s_hit, e_hit;
    logic             accept, count_en, s_ev, e_ev, done_ev;
    logic [3:0]       flags;
    logic [IDX_W-1:0] start_base, end_base, inflight_base;
    logic [IDX_W-1:0] start_fld, end_fld;
    logic [REC_W-1:0] rec;
    logic             underflow;
    logic             fifo_full, pop, wr_req, wr_acc, drop;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state; finish wins over loop_start/loop_done, DONE is terminal
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (finish)          state_nxt = DRAIN;
                else if (loop_start) state_nxt = RUN;
            end
            RUN: begin
                if (finish)         state_nxt = DRAIN;
                else if (loop_done) state_nxt = IDLE;
            end
            // leave as soon as the FIFO is (or is about to be) empty
            DRAIN: begin
                if (count == '0 || (count == CW'(1) && pop)) state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and event qualification
    always_comb begin
        busy     = (state == RUN);
        drained  = (state == DONE);
        s_hit    = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
        e_hit    = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
        accept   = (state == IDLE) & loop_start & ~finish;
        count_en = ((state == RUN) | accept) & ~finish;
        done_ev  = (state == RUN) & loop_done & ~finish;
        s_ev     = s_hit & count_en;
        e_ev     = e_hit & count_en;
        flags    = {done_ev, e_ev, s_ev, accept};
    end

    // record assembly; the acceptance cycle sees freshly cleared counters
    always_comb begin
        start_base    = accept ? '0 : start_cnt;
        end_base      = accept ? '0 : end_cnt;
        inflight_base = accept ? '0 : inflight;
        start_fld     = s_ev ? start_base : '0;
        end_fld       = e_ev ? end_base : '0;
        rec           = {flags, start_fld, end_fld, ts};
        underflow     = e_ev & ~s_ev & (inflight_base == '0);
    end

    // free-running timestamp
    always_ff @(posedge clock) begin
        if (reset) ts <= '0;
        else       ts <= ts + 1'b1;
    end

    // iteration counters; inflight never goes below zero
    always_ff @(posedge clock) begin
        if (reset) begin
            start_cnt <= '0;
            end_cnt   <= '0;
            inflight  <= '0;
        end else if (count_en) begin
            start_cnt <= start_base + IDX_W'(s_ev);
            end_cnt   <= end_base + IDX_W'(e_ev);
            if (s_ev && !e_ev)
                inflight <= inflight_base + 1'b1;
            else if (e_ev && !s_ev && inflight_base != '0)
                inflight <= inflight_base - 1'b1;
            else
                inflight <= inflight_base;
        end
    end

    // FIFO control; a full FIFO still takes a write when it pops that cycle
    always_comb begin
        out_valid = (count != '0);
        fifo_full = (count == CW'(DEPTH));
        pop       = out_valid & out_ready;
        wr_req    = |flags;
        wr_acc    = wr_req & (~fifo_full | pop);
        drop      = wr_req & fifo_full & ~pop;
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // FIFO storage; contents are qualified by count, so no reset needed
    always_ff @(posedge clock) begin
        if (wr_acc) mem[wr_ptr] <= rec;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !pop)      count <= count + CW'(1);
            else if (pop && !wr_acc) count <= count - CW'(1);
        end
    end

    // sticky status and saturating drop counter
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow      <= 1'b0;
            drop_count    <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            end
            if (underflow) err_underflow <= 1'b1;
        end
    end

endmodule
